// File: rtl/fft_reorder_if.sv
// Sample-stream bundle around the FFT output reorder buffer.
// The master modport is the upstream and downstream side; the slave modport is the block.
interface fft_reorder_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LOG_N = 6
);
   logic             di_en;
   logic [WIDTH-1:0] di_re;
   logic [WIDTH-1:0] di_im;
   logic             do_en;
   logic [WIDTH-1:0] do_re;
   logic [WIDTH-1:0] do_im;
   logic [LOG_N-1:0] do_idx;
   logic             frame_err;

   modport master (
      output di_en, di_re, di_im,
      input  do_en, do_re, do_im, do_idx, frame_err
   );

   modport slave (
      input  di_en, di_re, di_im,
      output do_en, do_re, do_im, do_idx, frame_err
   );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT frames and re-emits them in
// natural bin order at full rate.
module fft_reorder #(
   parameter int unsigned N      = 64,
   parameter int unsigned WIDTH  = 16,
   parameter bit          BITREV = 1'b1
) (
   input  logic clock,
   input  logic reset_n,
   fft_reorder_if.slave io
);
   localparam int unsigned LOG_N = $clog2(N);
   localparam int unsigned DW    = 2 * WIDTH;
   localparam int unsigned AW    = LOG_N + 1;

   typedef enum logic {W_IDLE, W_FILL}  wr_state_t;
   typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

   function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
      logic [LOG_N-1:0] r;
      for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
      return r;
   endfunction

   wr_state_t        wr_state, wr_state_nxt;
   logic [LOG_N-1:0] wr_cnt, wr_cnt_nxt;
   logic             wr_bank, wr_bank_nxt;
   logic             rd_start, rd_start_nxt;
   logic             frame_err_nxt;
   logic [AW-1:0]    wr_addr_c;

   rd_state_t        rd_state, rd_state_nxt;
   logic [LOG_N-1:0] rd_cnt, rd_cnt_nxt;
   logic             rd_bank, rd_bank_nxt;
   logic             rd_issue_c;
   logic [AW-1:0]    rd_addr_c;

   logic [DW-1:0]    mem [2*N];

   // Write side state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_state     <= W_IDLE;
         wr_cnt       <= '0;
         wr_bank      <= 1'b0;
         rd_start     <= 1'b0;
         io.frame_err <= 1'b0;
      end else begin
         wr_state     <= wr_state_nxt;
         wr_cnt       <= wr_cnt_nxt;
         wr_bank      <= wr_bank_nxt;
         rd_start     <= rd_start_nxt;
         io.frame_err <= frame_err_nxt;
      end
   end

   // Write side next state: count samples, flip banks on a full frame, drop partials
   always_comb begin
      wr_state_nxt  = wr_state;
      wr_cnt_nxt    = wr_cnt;
      wr_bank_nxt   = wr_bank;
      rd_start_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (io.di_en) begin
               wr_cnt_nxt   = wr_cnt + LOG_N'(1);
               wr_state_nxt = W_FILL;
            end
         end
         W_FILL: begin
            if (io.di_en) begin
               if (wr_cnt == LOG_N'(N-1)) begin
                  wr_cnt_nxt   = '0;
                  wr_bank_nxt  = ~wr_bank;
                  rd_start_nxt = 1'b1;
               end else begin
                  wr_cnt_nxt = wr_cnt + LOG_N'(1);
               end
            end else begin
               frame_err_nxt = (wr_cnt != '0);
               wr_cnt_nxt    = '0;
               wr_state_nxt  = W_IDLE;
            end
         end
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   assign wr_addr_c = {wr_bank, (BITREV ? bitrev(wr_cnt) : wr_cnt)};

   // Sample storage, both banks in one array; bank select is the address MSB
   always_ff @(posedge clock) begin
      if (io.di_en) mem[wr_addr_c] <= {io.di_re, io.di_im};
   end

   // Read side state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_state <= R_IDLE;
         rd_cnt   <= '0;
         rd_bank  <= 1'b0;
      end else begin
         rd_state <= rd_state_nxt;
         rd_cnt   <= rd_cnt_nxt;
         rd_bank  <= rd_bank_nxt;
      end
   end

   // Read side next state: the bank just filled is the one the writer left
   always_comb begin
      rd_state_nxt = rd_state;
      rd_cnt_nxt   = rd_cnt;
      rd_bank_nxt  = rd_bank;
      rd_issue_c   = 1'b0;
      case (rd_state)
         R_IDLE: begin
            if (rd_start) begin
               rd_state_nxt = R_DRAIN;
               rd_cnt_nxt   = '0;
               rd_bank_nxt  = ~wr_bank;
            end
         end
         R_DRAIN: begin
            rd_issue_c = 1'b1;
            if (rd_cnt == LOG_N'(N-1)) begin
               rd_cnt_nxt = '0;
               if (rd_start) rd_bank_nxt  = ~wr_bank;
               else          rd_state_nxt = R_IDLE;
            end else begin
               rd_cnt_nxt = rd_cnt + LOG_N'(1);
            end
         end
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   assign rd_addr_c = {rd_bank, rd_cnt};

   // Registered read port; data and index hold while no address is issued
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         io.do_en  <= 1'b0;
         io.do_re  <= '0;
         io.do_im  <= '0;
         io.do_idx <= '0;
      end else begin
         io.do_en <= rd_issue_c;
         if (rd_issue_c) begin
            io.do_re  <= mem[rd_addr_c][DW-1:WIDTH];
            io.do_im  <= mem[rd_addr_c][WIDTH-1:0];
            io.do_idx <= rd_cnt;
         end
      end
   end
endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: N=64 bit-reversed instance and N=16 straight instance.
module tb_fft_reorder;
   logic clock = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   fe_a = 0;
   int   fe_b = 0;

   typedef struct {
      int          cyc;
      int          idx;
      logic [15:0] re;
      logic [15:0] im;
   } out_t;

   typedef struct {
      int          idx;
      logic [15:0] re;
      logic [15:0] im;
   } vec_t;

   out_t        qa[$];
   out_t        qb[$];
   logic [15:0] last_re [64];
   logic [15:0] last_im [64];
   vec_t        tbl [6];

   fft_reorder_if #(.WIDTH(16), .LOG_N(6)) ifa ();
   fft_reorder_if #(.WIDTH(16), .LOG_N(4)) ifb ();

   fft_reorder #(.N(64), .WIDTH(16), .BITREV(1'b1)) dut_a (.clock(clock), .reset_n(reset_n), .io(ifa));
   fft_reorder #(.N(16), .WIDTH(16), .BITREV(1'b0)) dut_b (.clock(clock), .reset_n(reset_n), .io(ifb));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (ifa.do_en) qa.push_back('{cyc, int'(ifa.do_idx), ifa.do_re, ifa.do_im});
      if (ifb.do_en) qb.push_back('{cyc, int'(ifb.do_idx), ifb.do_re, ifb.do_im});
      if (ifa.frame_err) fe_a++;
      if (ifb.frame_err) fe_b++;
   end

   function automatic int brev6(input int v);
      int r = 0;
      for (int b = 0; b < 6; b++) if (((v >> b) & 1) != 0) r |= (1 << (5 - b));
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int qsize(input int which);
      return (which == 0) ? qa.size() : qb.size();
   endfunction

   task automatic send(input int which, input int base, input int count, output int t0);
      t0 = 0;
      for (int k = 0; k < count; k++) begin
         @(posedge clock); #1;
         if (k == 0) t0 = cyc + 1;
         if (which == 0) begin
            ifa.di_en = 1'b1; ifa.di_re = 16'(base + k); ifa.di_im = 16'(-(base + k));
         end else begin
            ifb.di_en = 1'b1; ifb.di_re = 16'(base + k); ifb.di_im = 16'(-(base + k));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock); #1;
         ifa.di_en = 1'b0;
         ifb.di_en = 1'b0;
      end
   endtask

   task automatic wait_out(input int which, input int n, input int budget, input string tag);
      int w = 0;
      while (qsize(which) < n && w < budget) begin
         @(negedge clock); #1;
         w++;
      end
      chk({tag, " timeout"}, 64'(qsize(which) >= n), 64'd1);
   endtask

   // Pops one frame and checks timing, index order and reordered data
   task automatic check_frame(input int which, input int t_first, input int base, input string tag);
      int   n = (which == 0) ? 64 : 16;
      int   ev;
      out_t e;
      wait_out(which, n, 400, tag);
      for (int i = 0; i < n; i++) begin
         if (qsize(which) == 0) break;
         e  = (which == 0) ? qa.pop_front() : qb.pop_front();
         ev = base + ((which == 0) ? brev6(i) : i);
         chk({tag, " cycle"}, 64'(e.cyc), 64'(t_first + i));
         chk({tag, " idx"}, 64'(e.idx), 64'(i));
         chk({tag, " data"}, {32'd0, e.re, e.im}, {32'd0, 16'(ev), 16'(-ev)});
         if (i < 64) begin
            last_re[i] = e.re;
            last_im[i] = e.im;
         end
      end
   endtask

   initial begin
      int t0, t1, fe0;

      tbl[0] = '{0,  16'd0,  16'd0};
      tbl[1] = '{1,  16'd32, 16'hffe0};
      tbl[2] = '{2,  16'd16, 16'hfff0};
      tbl[3] = '{3,  16'd48, 16'hffd0};
      tbl[4] = '{5,  16'd40, 16'hffd8};
      tbl[5] = '{63, 16'd63, 16'hffc1};

      reset_n = 1'b0;
      ifa.di_en = 1'b0; ifa.di_re = '0; ifa.di_im = '0;
      ifb.di_en = 1'b0; ifb.di_re = '0; ifb.di_im = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset do_en", 64'(ifa.do_en), 64'd0);
      chk("reset do_re", 64'(ifa.do_re), 64'd0);
      chk("reset do_im", 64'(ifa.do_im), 64'd0);
      chk("reset do_idx", 64'(ifa.do_idx), 64'd0);
      chk("reset frame_err", 64'(ifa.frame_err), 64'd0);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);

      // Single frame, bit-reversed arrival
      send(0, 0, 64, t0);
      idle(1);
      check_frame(0, t0 + 65, 0, "t1");
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t1 table re idx%0d", tbl[i].idx), 64'(last_re[tbl[i].idx]), 64'(tbl[i].re));
         chk($sformatf("t1 table im idx%0d", tbl[i].idx), 64'(last_im[tbl[i].idx]), 64'(tbl[i].im));
      end

      // Back-to-back frames, second offset by 100
      send(0, 0, 64, t0);
      send(0, 100, 64, t1);
      idle(1);
      check_frame(0, t0 + 65, 0, "t2 f1");
      check_frame(0, t0 + 129, 100, "t2 f2");

      // Partial frame discarded, then a full frame
      fe0 = fe_a;
      send(0, 500, 20, t0);
      idle(4);
      send(0, 200, 64, t1);
      idle(1);
      check_frame(0, t1 + 65, 200, "t3");
      repeat (80) @(negedge clock);
      chk("t3 frame_err pulses", 64'(fe_a - fe0), 64'd1);
      chk("t3 extra outputs", 64'(qa.size()), 64'd0);

      // Reset asserted in the middle of a drain
      send(0, 0, 64, t0);
      idle(1);
      wait_out(0, 10, 200, "t4 pre");
      @(posedge clock); #1;
      chk("t4 idx before reset", 64'(ifa.do_idx), 64'd10);
      chk("t4 en before reset", 64'(ifa.do_en), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("t4 do_en in reset", 64'(ifa.do_en), 64'd0);
      chk("t4 do_re in reset", 64'(ifa.do_re), 64'd0);
      chk("t4 do_im in reset", 64'(ifa.do_im), 64'd0);
      chk("t4 do_idx in reset", 64'(ifa.do_idx), 64'd0);
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      qa.delete();
      repeat (2) @(posedge clock);
      send(0, 50, 64, t0);
      idle(1);
      check_frame(0, t0 + 65, 50, "t4 post");

      // Straight-order N=16 instance
      send(1, 0, 16, t0);
      idle(1);
      check_frame(1, t0 + 17, 0, "t5");

      // Two frames with a 5-cycle gap
      fe0 = fe_a;
      send(0, 300, 64, t0);
      idle(5);
      send(0, 400, 64, t1);
      idle(1);
      check_frame(0, t0 + 65, 300, "t6 f1");
      check_frame(0, t0 + 65 + 69, 400, "t6 f2");
      chk("t6 frame_err", 64'(fe_a - fe0), 64'd0);

      repeat (20) @(negedge clock);
      chk("end queue a", 64'(qa.size()), 64'd0);
      chk("end queue b", 64'(qb.size()), 64'd0);
      chk("end frame_err b", 64'(fe_b), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
